// File: rtl/triangle_sequencer.sv
// Lock-step triangle pipeline sequencer: issues triangles through STAGES stages.
// Optional abort input enabled by defining TRIANGLE_SEQ_ABORT_EN.
module triangle_sequencer #(
    parameter int MADDR_WIDTH   = 32,
    parameter int STAGES        = 3,
    parameter int COUNT_WIDTH   = 32,
    parameter int VERTEX_STRIDE = 6,
    parameter int COLOR_STRIDE  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [COUNT_WIDTH-1:0] triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    input  logic [STAGES-1:0]      stage_eoc,
    output logic [STAGES-1:0]      stage_start,
    output logic [STAGES-1:0]      stage_load,
    output logic [MADDR_WIDTH-1:0] fetch_addr_vertex,
    output logic [MADDR_WIDTH-1:0] fetch_addr_color,
    output logic                   busy,
    output logic                   frame_end,
    output logic                   irq,
    input  logic                   irq_clear
`ifdef TRIANGLE_SEQ_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [STAGES-1:0]      valid_q, valid_d;
    logic [STAGES-1:0]      done_q, done_d;
    logic [STAGES-1:0]      start_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   step;
    logic                   step_ok;
    logic                   abort_hit;
    logic                   irq_set;
    logic                   accept;

    assign accept    = (state_q == IDLE) && frame_start;
    assign busy      = (state_q != IDLE);
    assign frame_end = (state_q == DONE);

`ifdef TRIANGLE_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q == RUN);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        step_ok = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (valid_q[i] && !done_q[i] && !stage_eoc[i]) begin
                step_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        done_d   = done_q | (stage_eoc & valid_q);
        issued_d = issued_q;
        start_d  = '0;
        step     = 1'b0;
        irq_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = RUN;
                    issued_d = '0;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_d = IDLE;
                    valid_d = '0;
                    done_d  = '0;
                end else begin
                    step = step_ok;
                    if (step) begin
                        for (int i = STAGES - 1; i > 0; i--) begin
                            valid_d[i] = valid_q[i-1];
                        end
                        valid_d[0] = (issued_q < count_q);
                        done_d     = '0;
                        start_d    = valid_d;
                        if (issued_q < count_q) begin
                            issued_d = issued_q + COUNT_WIDTH'(1);
                        end
                    end
                    // Finish on the edge that empties the pipe, not a cycle later
                    if (valid_d == '0 && issued_d == count_q) begin
                        state_d = DONE;
                        irq_set = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stage_load = '0;
        for (int i = 1; i < STAGES; i++) begin
            stage_load[i] = step && valid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            done_q      <= '0;
            issued_q    <= '0;
            count_q     <= '0;
            stage_start <= '0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            issued_q    <= issued_d;
            stage_start <= start_d;
            if (accept) begin
                count_q <= triangles_count;
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clear) begin
                irq <= 1'b0;
            end
        end
    end

    // Address moves on after the cycle that presented it to stage 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr_vertex <= '0;
            fetch_addr_color  <= '0;
        end else if (accept) begin
            fetch_addr_vertex <= base_addr_vertex;
            fetch_addr_color  <= base_addr_color;
        end else if (stage_start[0]) begin
            fetch_addr_vertex <= fetch_addr_vertex + MADDR_WIDTH'(VERTEX_STRIDE);
            fetch_addr_color  <= fetch_addr_color + MADDR_WIDTH'(COLOR_STRIDE);
        end
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer with STAGES=3 and default strides.
module tb_triangle_sequencer;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic [31:0] triangles_count;
    logic [31:0] base_addr_vertex;
    logic [31:0] base_addr_color;
    logic [2:0]  stage_eoc;
    logic [2:0]  stage_start;
    logic [2:0]  stage_load;
    logic [31:0] fetch_addr_vertex;
    logic [31:0] fetch_addr_color;
    logic        busy;
    logic        frame_end;
    logic        irq;
    logic        irq_clear;
    logic        eoc1;
`ifdef TRIANGLE_SEQ_ABORT_EN
    logic        abort;
`endif

    int total;
    int bad;
    int fe_cnt;

    assign stage_eoc = {1'b1, eoc1, 1'b1};

    triangle_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .frame_start       (frame_start),
        .triangles_count   (triangles_count),
        .base_addr_vertex  (base_addr_vertex),
        .base_addr_color   (base_addr_color),
        .stage_eoc         (stage_eoc),
        .stage_start       (stage_start),
        .stage_load        (stage_load),
        .fetch_addr_vertex (fetch_addr_vertex),
        .fetch_addr_color  (fetch_addr_color),
        .busy              (busy),
        .frame_end         (frame_end),
        .irq               (irq),
        .irq_clear         (irq_clear)
`ifdef TRIANGLE_SEQ_ABORT_EN
        ,
        .abort             (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] cnt, input logic [31:0] bv,
                          input logic [31:0] bc);
        triangles_count  = cnt;
        base_addr_vertex = bv;
        base_addr_color  = bc;
        frame_start      = 1'b1;
        tick();
        frame_start      = 1'b0;
    endtask

    task automatic drain(input string tag);
        fe_cnt = 0;
        for (int i = 0; i < 40 && fe_cnt == 0; i++) begin
            if (frame_end) fe_cnt++;
            else tick();
        end
        chk(tag, 64'(fe_cnt), 64'd1);
        tick();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        frame_start      = 1'b0;
        triangles_count  = '0;
        base_addr_vertex = '0;
        base_addr_color  = '0;
        irq_clear        = 1'b0;
        eoc1             = 1'b1;
`ifdef TRIANGLE_SEQ_ABORT_EN
        abort            = 1'b0;
`endif
        #12;
        chk("rst_start", 64'(stage_start), 64'd0);
        chk("rst_load", 64'(stage_load), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fe", 64'(frame_end), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_addr_v", 64'(fetch_addr_vertex), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // count=1, eoc high
        launch(32'd1, 32'h100, 32'h200);
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_t1_start", 64'(stage_start), 64'd0);
        tick();
        chk("c1_t2_start", 64'(stage_start), 64'b001);
        chk("c1_t2_load", 64'(stage_load), 64'b010);
        chk("c1_t2_addr_v", 64'(fetch_addr_vertex), 64'h100);
        chk("c1_t2_addr_c", 64'(fetch_addr_color), 64'h200);
        tick();
        chk("c1_t3_start", 64'(stage_start), 64'b010);
        chk("c1_t3_load", 64'(stage_load), 64'b100);
        tick();
        chk("c1_t4_start", 64'(stage_start), 64'b100);
        chk("c1_t4_fe", 64'(frame_end), 64'd0);
        tick();
        chk("c1_t5_fe", 64'(frame_end), 64'd1);
        chk("c1_t5_irq", 64'(irq), 64'd1);
        chk("c1_t5_start", 64'(stage_start), 64'd0);
        tick();
        chk("c1_t6_fe", 64'(frame_end), 64'd0);
        chk("c1_t6_busy", 64'(busy), 64'd0);
        chk("c1_t6_irq", 64'(irq), 64'd1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("c1_irq_clr", 64'(irq), 64'd0);

        // count=4, eoc high: back-to-back issue
        launch(32'd4, 32'h100, 32'h200);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("c4_start0", 64'(stage_start[0]), 64'd1);
            chk("c4_addr_v", 64'(fetch_addr_vertex), 64'(32'h100 + 6 * k));
            chk("c4_addr_c", 64'(fetch_addr_color), 64'(32'h200 + 2 * k));
            tick();
        end
        chk("c4_t6_start0", 64'(stage_start[0]), 64'd0);
        fe_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (frame_end) fe_cnt++;
            tick();
        end
        chk("c4_fe_once", 64'(fe_cnt), 64'd1);
        chk("c4_irq_hold", 64'(irq), 64'd1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("c4_irq_clr", 64'(irq), 64'd0);

        // count=3, stage 1 eoc pulses 5 cycles after each of its starts
        eoc1 = 1'b0;
        launch(32'd3, 32'h100, 32'h200);
        tick();
        chk("c3_t2_start", 64'(stage_start), 64'b001);
        chk("c3_t2_load", 64'(stage_load), 64'b010);
        tick();
        chk("c3_t3_start", 64'(stage_start), 64'b011);
        chk("c3_t3_addr_v", 64'(fetch_addr_vertex), 64'h106);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("c3_hold1_start", 64'(stage_start), 64'd0);
            chk("c3_hold1_load", 64'(stage_load), 64'd0);
        end
        tick();
        eoc1 = 1'b1;
        #1;
        chk("c3_t8_load", 64'(stage_load), 64'b110);
        tick();
        eoc1 = 1'b0;
        chk("c3_t9_start", 64'(stage_start), 64'b111);
        chk("c3_t9_addr_v", 64'(fetch_addr_vertex), 64'h10C);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("c3_hold2_start", 64'(stage_start), 64'd0);
        end
        tick();
        eoc1 = 1'b1;
        #1;
        chk("c3_t14_load", 64'(stage_load), 64'b110);
        tick();
        eoc1 = 1'b0;
        chk("c3_t15_start", 64'(stage_start), 64'b110);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("c3_hold3_start", 64'(stage_start), 64'd0);
        end
        tick();
        eoc1 = 1'b1;
        #1;
        chk("c3_t20_load", 64'(stage_load), 64'b100);
        tick();
        chk("c3_t21_start", 64'(stage_start), 64'b100);
        chk("c3_t21_fe", 64'(frame_end), 64'd0);
        tick();
        chk("c3_t22_fe", 64'(frame_end), 64'd1);
        tick();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;

        // count=0, with a frame_start retried during RUN
        launch(32'd0, 32'h100, 32'h200);
        chk("c0_t1_busy", 64'(busy), 64'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("c0_t2_fe", 64'(frame_end), 64'd1);
        chk("c0_t2_irq", 64'(irq), 64'd1);
        chk("c0_t2_start", 64'(stage_start), 64'd0);
        tick();
        chk("c0_t3_fe", 64'(frame_end), 64'd0);
        chk("c0_t3_busy", 64'(busy), 64'd0);
        tick();
        chk("c0_t4_fe", 64'(frame_end), 64'd0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;

        // Address wrap
        eoc1 = 1'b1;
        launch(32'd2, 32'hFFFF_FFFC, 32'h200);
        tick();
        chk("wr_addr0", 64'(fetch_addr_vertex), 64'hFFFF_FFFC);
        tick();
        chk("wr_addr1", 64'(fetch_addr_vertex), 64'h0000_0002);
        drain("wr_done");
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;

        // Reset mid-frame
        launch(32'd4, 32'h100, 32'h200);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mr_start", 64'(stage_start), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_addr_v", 64'(fetch_addr_vertex), 64'd0);
        tick();
        chk("mr_fe", 64'(frame_end), 64'd0);
        chk("mr_irq", 64'(irq), 64'd0);
        reset_n = 1'b1;
        tick();
        launch(32'd1, 32'h300, 32'h400);
        tick();
        chk("mr_re_start", 64'(stage_start), 64'b001);
        chk("mr_re_addr_v", 64'(fetch_addr_vertex), 64'h300);
        drain("mr_re_done");

`ifdef TRIANGLE_SEQ_ABORT_EN
        launch(32'd4, 32'h100, 32'h200);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_start", 64'(stage_start), 64'd0);
        chk("ab_fe", 64'(frame_end), 64'd0);
        chk("ab_irq", 64'(irq), 64'd1);
        launch(32'd1, 32'h500, 32'h600);
        tick();
        chk("ab_re_start", 64'(stage_start), 64'b001);
        chk("ab_re_addr_v", 64'(fetch_addr_vertex), 64'h500);
        drain("ab_re_done");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/triangle_sequencer.md
TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 SHALL have parameter MADDR_WIDTH, default 32: width of vertex and colour memory addresses.
REQ-002 SHALL have parameter STAGES, default 3: number of lock-step pipeline stages (fetch, vertex, pixel, ...); legal range 1..8.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32: width of the triangle counter.
REQ-004 SHALL have parameter VERTEX_STRIDE, default 6: byte increment of the vertex address per triangle.
REQ-005 SHALL have parameter COLOR_STRIDE, default 2: byte increment of the colour address per triangle.
REQ-006 SHALL have ports, in this order:
  clk  in  1  sole clock; all state updates on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  frame_start  in  1  single-cycle frame request
  triangles_count  in  COUNT_WIDTH  triangles in frame; sampled at accept
  base_addr_vertex  in  MADDR_WIDTH  first vertex address; sampled at accept
  base_addr_color  in  MADDR_WIDTH  first colour address; sampled at accept
  stage_eoc  in  STAGES  per-stage end-of-computation pulse or level
  stage_start  out  STAGES  per-stage single-cycle start pulse
  stage_load  out  STAGES  per-stage inter-stage register enable; bit 0 always 0
  fetch_addr_vertex  out  MADDR_WIDTH  vertex address for stage 0, valid with stage_start[0]
  fetch_addr_color  out  MADDR_WIDTH  colour address for stage 0, valid with stage_start[0]
  busy  out  1  high outside IDLE
  frame_end  out  1  single-cycle pulse on frame completion
  irq  out  1  sticky level, set with frame_end
  irq_clear  in  1  clears irq

Function
REQ-007 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on frame_start; RUN->DONE when issued==count and no stage holds a token; DONE->IDLE unconditionally after one cycle.
REQ-008 SHALL ignore frame_start in RUN and DONE.
REQ-009 SHALL keep a token bit valid[i] per stage and a sticky done[i] set by stage_eoc[i] while valid[i].
REQ-010 SHALL compute step (combinational, RUN only) = AND over i of (!valid[i] || done[i] || stage_eoc[i]).
REQ-011 On step: valid[0] <= (issued<count); valid[i] <= valid[i-1] for i>0; all done[] cleared; issued increments when valid[0] is loaded with 1.
REQ-012 stage_load[i] (i>0) SHALL equal step && valid[i-1], same cycle as step.
REQ-013 stage_start[i] SHALL pulse exactly one cycle after a step that loads valid[i] with 1.
REQ-014 Addresses SHALL load bases at accept and advance by VERTEX_STRIDE/COLOR_STRIDE after each issued triangle, modulo 2^MADDR_WIDTH.
REQ-015 Latency: frame_start at cycle T -> first step T+1 -> stage_start[0] at T+2 with fetch_addr_vertex == base_addr_vertex.
REQ-016 triangles_count == 0 SHALL issue no stage_start and assert frame_end at T+2.
REQ-017 frame_end SHALL pulse in the DONE cycle; irq SHALL set in the same cycle; irq_clear SHALL lose to a simultaneous set.
REQ-018 stage_eoc on a stage without a token SHALL be ignored.

Reset
REQ-019 While reset_n low: state IDLE, valid/done/issued zero, addresses zero, stage_start, stage_load, busy, frame_end, irq all 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame immediately with no frame_end and no irq.

Configuration
REQ-021 With TRIANGLE_SEQ_ABORT_EN defined: input port abort (1 bit) SHALL exist; abort high in RUN SHALL clear valid[]/done[] and return to IDLE next cycle, with no frame_end and irq unchanged; abort in IDLE/DONE ignored.
REQ-022 Without TRIANGLE_SEQ_ABORT_EN: no abort port; a frame ends only via DONE or reset.

Verification
REQ-023 count=1, STAGES=3, eoc tied high, base_v=0x100 -> stage_start[0],[1],[2] on T+2,T+3,T+4; addr_v 0x100; frame_end at T+5.
REQ-024 count=4, eoc tied high -> addr_v 0x100,0x106,0x10C,0x112 and addr_c 0x200,0x202,0x204,0x206; frame_end once; irq high until irq_clear.
REQ-025 count=3, stage_eoc[1] delayed 5 cycles per triangle -> no step and no stage_start while stage 1 pending; triangle order and stage_load timing preserved.
REQ-026 count=0 -> no stage_start, frame_end at T+2, irq set; frame_start during RUN ignored (single frame_end).
REQ-027 base_v=0xFFFF_FFFC, count=2 -> second addr_v 0x0000_0002 (wrap).
REQ-028 reset_n low mid-frame, then with TRIANGLE_SEQ_ABORT_EN abort mid-frame -> all outputs zero / IDLE, no frame_end, next frame_start runs normally.
